// File: rtl/active_list_retire_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | active_list_retire_pkg : sizes and payload type for the ROB       |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
package active_list_retire_pkg;

    localparam int SIZE_ACTIVE_LIST     = 64;
    localparam int SIZE_ACTIVE_LIST_LOG = 6;
    localparam int SIZE_PHYSICAL_LOG    = 7;
    localparam int DISPATCH_WIDTH       = 4;

    typedef logic [SIZE_ACTIVE_LIST_LOG-1:0] alIdx_t;

    typedef struct packed {
        logic                         hasDest;
        logic [SIZE_PHYSICAL_LOG-1:0] oldPhyReg;
    } alPayload_t;

endpackage
`default_nettype wire

// File: rtl/al_payload_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | al_payload_ram : 4R4W entry payload store, async read            |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module al_payload_ram
    import active_list_retire_pkg::*;
(
    input  logic       clk,
    input  logic       wrEn,
    input  alIdx_t     wrAddr [DISPATCH_WIDTH],
    input  alPayload_t wrData [DISPATCH_WIDTH],
    input  alIdx_t     rdAddr [DISPATCH_WIDTH],
    output alPayload_t rdData [DISPATCH_WIDTH]
);

    alPayload_t mem [SIZE_ACTIVE_LIST];

    // Write addresses are always four consecutive indices, so ports never collide.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                mem[wrAddr[k]] <= wrData[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_rd
            assign rdData[k] = mem[rdAddr[k]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/active_list_retire.sv
`default_nettype none
// +------------------------------------------------------------------+
// | active_list_retire : in-order active list, retires up to 4/cycle |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module active_list_retire
    import active_list_retire_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            dispatchEn_i,
    input  logic                            hasDest0_i,
    input  logic                            hasDest1_i,
    input  logic                            hasDest2_i,
    input  logic                            hasDest3_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]    oldPhyReg0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]    oldPhyReg1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]    oldPhyReg2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]    oldPhyReg3_i,
    input  logic                            doneValid0_i,
    input  logic                            doneValid1_i,
    input  logic                            doneValid2_i,
    input  logic                            doneValid3_i,
    input  logic [SIZE_ACTIVE_LIST_LOG-1:0] doneIdx0_i,
    input  logic [SIZE_ACTIVE_LIST_LOG-1:0] doneIdx1_i,
    input  logic [SIZE_ACTIVE_LIST_LOG-1:0] doneIdx2_i,
    input  logic [SIZE_ACTIVE_LIST_LOG-1:0] doneIdx3_i,
    input  logic                            doneExcept0_i,
    input  logic                            doneExcept1_i,
    input  logic                            doneExcept2_i,
    input  logic                            doneExcept3_i,
    output logic [SIZE_ACTIVE_LIST_LOG-1:0] alTail_o,
    output logic [SIZE_ACTIVE_LIST_LOG-1:0] alHead_o,
    output logic [SIZE_ACTIVE_LIST_LOG:0]   alCount_o,
    output logic                            alFull_o,
    output logic                            commitValid0_o,
    output logic                            commitValid1_o,
    output logic                            commitValid2_o,
    output logic                            commitValid3_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]    commitReg0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]    commitReg1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]    commitReg2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]    commitReg3_o,
    output logic [2:0]                      commitCount_o,
    output logic                            recoverFlag_o
);

    localparam int CW = SIZE_ACTIVE_LIST_LOG + 1;

    alIdx_t                       head;
    alIdx_t                       tail;
    logic [CW-1:0]                count;
    logic [SIZE_ACTIVE_LIST-1:0]  doneBits;
    logic [SIZE_ACTIVE_LIST-1:0]  exceptBits;
    logic [SIZE_ACTIVE_LIST-1:0]  doneNext;
    logic [SIZE_ACTIVE_LIST-1:0]  exceptNext;
    logic                         recoverFlag;

    logic [DISPATCH_WIDTH-1:0]    commitValidR;
    logic [SIZE_PHYSICAL_LOG-1:0] commitRegR [DISPATCH_WIDTH];
    logic [2:0]                   commitCountR;

    logic                         hasDestIn  [DISPATCH_WIDTH];
    logic [SIZE_PHYSICAL_LOG-1:0] oldPhyIn   [DISPATCH_WIDTH];
    logic                         wbValid    [DISPATCH_WIDTH];
    alIdx_t                       wbIdx      [DISPATCH_WIDTH];
    logic                         wbExcept   [DISPATCH_WIDTH];
    alIdx_t                       wbOffset   [DISPATCH_WIDTH];
    logic [DISPATCH_WIDTH-1:0]    wbLive;

    alIdx_t                       wrAddr [DISPATCH_WIDTH];
    alPayload_t                   wrData [DISPATCH_WIDTH];
    alIdx_t                       rdAddr [DISPATCH_WIDTH];
    alPayload_t                   rdData [DISPATCH_WIDTH];

    logic [DISPATCH_WIDTH-1:0]    retire;
    logic [2:0]                   retireCnt;
    logic                         retireBlocked;
    logic                         flushNow;
    logic                         dispatchFire;

    assign hasDestIn = '{hasDest0_i, hasDest1_i, hasDest2_i, hasDest3_i};
    assign oldPhyIn  = '{oldPhyReg0_i, oldPhyReg1_i, oldPhyReg2_i, oldPhyReg3_i};
    assign wbValid   = '{doneValid0_i, doneValid1_i, doneValid2_i, doneValid3_i};
    assign wbIdx     = '{doneIdx0_i, doneIdx1_i, doneIdx2_i, doneIdx3_i};
    assign wbExcept  = '{doneExcept0_i, doneExcept1_i, doneExcept2_i, doneExcept3_i};

    generate
        for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_port
            assign rdAddr[k]         = head + alIdx_t'(k);
            assign wrAddr[k]         = tail + alIdx_t'(k);
            assign wrData[k].hasDest   = hasDestIn[k];
            assign wrData[k].oldPhyReg = oldPhyIn[k];
            // Live only if occupied now and not leaving the list this cycle.
            assign wbOffset[k] = wbIdx[k] - head;
            assign wbLive[k]   = wbValid[k] && (CW'(wbOffset[k]) < count)
                                 && (wbOffset[k] >= alIdx_t'(retireCnt));
        end
    endgenerate

    al_payload_ram u_payload (
        .clk    (clk),
        .wrEn   (dispatchFire),
        .wrAddr (wrAddr),
        .wrData (wrData),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    assign alFull_o     = count > CW'(SIZE_ACTIVE_LIST - DISPATCH_WIDTH);
    assign dispatchFire = dispatchEn_i && !alFull_o && !recoverFlag && !flushNow;

    always_comb begin
        retire        = '0;
        retireCnt     = '0;
        retireBlocked = 1'b0;
        flushNow      = 1'b0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (!retireBlocked && (count > CW'(k)) && doneBits[rdAddr[k]]) begin
                retire[k] = 1'b1;
                retireCnt = retireCnt + 3'd1;
                if (exceptBits[rdAddr[k]]) begin
                    flushNow      = 1'b1;
                    retireBlocked = 1'b1;
                end
            end else begin
                retireBlocked = 1'b1;
            end
        end
    end

    always_comb begin
        doneNext   = doneBits;
        exceptNext = exceptBits;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (retire[k]) begin
                doneNext[rdAddr[k]]   = 1'b0;
                exceptNext[rdAddr[k]] = 1'b0;
            end
            if (dispatchFire) begin
                doneNext[wrAddr[k]]   = 1'b0;
                exceptNext[wrAddr[k]] = 1'b0;
            end
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (wbLive[k]) begin
                doneNext[wbIdx[k]]   = 1'b1;
                exceptNext[wbIdx[k]] = exceptNext[wbIdx[k]] | wbExcept[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            doneBits     <= '0;
            exceptBits   <= '0;
            recoverFlag  <= 1'b0;
            commitValidR <= '0;
            commitCountR <= '0;
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                commitRegR[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                commitValidR[k] <= retire[k] && rdData[k].hasDest;
                commitRegR[k]   <= (retire[k] && rdData[k].hasDest) ? rdData[k].oldPhyReg : '0;
            end
            commitCountR <= retireCnt;
            recoverFlag  <= flushNow;
            if (flushNow) begin
                head       <= tail;
                count      <= '0;
                doneBits   <= '0;
                exceptBits <= '0;
            end else begin
                head       <= head + alIdx_t'(retireCnt);
                tail       <= dispatchFire ? tail + alIdx_t'(DISPATCH_WIDTH) : tail;
                count      <= count + (dispatchFire ? CW'(DISPATCH_WIDTH) : '0) - CW'(retireCnt);
                doneBits   <= doneNext;
                exceptBits <= exceptNext;
            end
        end
    end

    assign alHead_o       = head;
    assign alTail_o       = tail;
    assign alCount_o      = count;
    assign recoverFlag_o  = recoverFlag;
    assign commitCount_o  = commitCountR;
    assign commitValid0_o = commitValidR[0];
    assign commitValid1_o = commitValidR[1];
    assign commitValid2_o = commitValidR[2];
    assign commitValid3_o = commitValidR[3];
    assign commitReg0_o   = commitRegR[0];
    assign commitReg1_o   = commitRegR[1];
    assign commitReg2_o   = commitRegR[2];
    assign commitReg3_o   = commitRegR[3];

endmodule
`default_nettype wire

// File: tb/tb_active_list_retire.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_active_list_retire : directed + random bench with queue model |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_active_list_retire;

    localparam int SZ = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dispatchEn;
    logic       hasDest [4];
    logic [6:0] oldPhy  [4];
    logic       dv [4];
    logic [5:0] di [4];
    logic       de [4];

    logic [5:0] alTail, alHead;
    logic [6:0] alCount;
    logic       alFull;
    logic       cv0, cv1, cv2, cv3;
    logic [6:0] cr0, cr1, cr2, cr3;
    logic [2:0] commitCount;
    logic       recoverFlag;

    always #5 clk = ~clk;

    active_list_retire dut (
        .clk(clk), .reset(reset), .dispatchEn_i(dispatchEn),
        .hasDest0_i(hasDest[0]), .hasDest1_i(hasDest[1]), .hasDest2_i(hasDest[2]), .hasDest3_i(hasDest[3]),
        .oldPhyReg0_i(oldPhy[0]), .oldPhyReg1_i(oldPhy[1]), .oldPhyReg2_i(oldPhy[2]), .oldPhyReg3_i(oldPhy[3]),
        .doneValid0_i(dv[0]), .doneValid1_i(dv[1]), .doneValid2_i(dv[2]), .doneValid3_i(dv[3]),
        .doneIdx0_i(di[0]), .doneIdx1_i(di[1]), .doneIdx2_i(di[2]), .doneIdx3_i(di[3]),
        .doneExcept0_i(de[0]), .doneExcept1_i(de[1]), .doneExcept2_i(de[2]), .doneExcept3_i(de[3]),
        .alTail_o(alTail), .alHead_o(alHead), .alCount_o(alCount), .alFull_o(alFull),
        .commitValid0_o(cv0), .commitValid1_o(cv1), .commitValid2_o(cv2), .commitValid3_o(cv3),
        .commitReg0_o(cr0), .commitReg1_o(cr1), .commitReg2_o(cr2), .commitReg3_o(cr3),
        .commitCount_o(commitCount), .recoverFlag_o(recoverFlag)
    );

    // Reference model: the active list as a program-ordered queue of instructions.
    typedef struct {
        bit hasDest;
        int oldReg;
        bit done;
        bit exc;
        int idx;
    } ent_t;

    ent_t q[$];
    int   mHead, mTail, eCnt;
    bit   mRecover;
    bit   eValid [4];
    int   eReg   [4];
    int   errors = 0;
    int   checks = 0;

    task automatic modelReset();
        q.delete();
        mHead = 0; mTail = 0; eCnt = 0; mRecover = 0;
        for (int k = 0; k < 4; k++) begin eValid[k] = 0; eReg[k] = 0; end
    endtask

    task automatic modelStep();
        int   n, occ;
        bit   flush, disp;
        ent_t e;
        n = 0; flush = 0; occ = q.size();
        for (int k = 0; k < 4; k++) begin eValid[k] = 0; eReg[k] = 0; end
        while (n < 4 && q.size() > 0 && !flush && q[0].done) begin
            e = q.pop_front();
            eValid[n] = e.hasDest;
            eReg[n]   = e.hasDest ? e.oldReg : 0;
            if (e.exc) flush = 1;
            n++;
        end
        eCnt = n;
        disp = dispatchEn && (occ <= SZ - 4) && !mRecover && !flush;
        if (flush) begin
            q.delete();
            mHead = mTail;
        end else begin
            mHead = (mHead + n) % SZ;
            for (int k = 0; k < 4; k++) begin
                if (dv[k]) begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].idx == int'(di[k])) begin
                            q[i].done = 1;
                            q[i].exc  = q[i].exc | de[k];
                        end
                    end
                end
            end
            if (disp) begin
                for (int k = 0; k < 4; k++) begin
                    e.hasDest = hasDest[k]; e.oldReg = int'(oldPhy[k]);
                    e.done = 0; e.exc = 0; e.idx = (mTail + k) % SZ;
                    q.push_back(e);
                end
                mTail = (mTail + 4) % SZ;
            end
        end
        mRecover = flush;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("alHead", 32'(alHead), mHead);
        chk("alTail", 32'(alTail), mTail);
        chk("alCount", 32'(alCount), q.size());
        chk("alFull", 32'(alFull), 32'(q.size() > SZ - 4));
        chk("commitValid0", 32'(cv0), 32'(eValid[0]));
        chk("commitValid1", 32'(cv1), 32'(eValid[1]));
        chk("commitValid2", 32'(cv2), 32'(eValid[2]));
        chk("commitValid3", 32'(cv3), 32'(eValid[3]));
        chk("commitReg0", 32'(cr0), eReg[0]);
        chk("commitReg1", 32'(cr1), eReg[1]);
        chk("commitReg2", 32'(cr2), eReg[2]);
        chk("commitReg3", 32'(cr3), eReg[3]);
        chk("commitCount", 32'(commitCount), eCnt);
        chk("recoverFlag", 32'(recoverFlag), 32'(mRecover));
    endtask

    task automatic idle();
        dispatchEn = 0;
        for (int k = 0; k < 4; k++) begin
            hasDest[k] = 0; oldPhy[k] = '0; dv[k] = 0; di[k] = '0; de[k] = 0;
        end
    endtask

    task automatic setDisp(input bit [3:0] hd, input int base);
        dispatchEn = 1;
        for (int k = 0; k < 4; k++) begin
            hasDest[k] = hd[k];
            oldPhy[k]  = 7'(base + k);
        end
    endtask

    task automatic setWb(input int k, input int idx, input bit exc);
        dv[k] = 1; di[k] = 6'(idx); de[k] = exc;
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1ns after the rising edge.
    task automatic step();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        idle();
    endtask

    initial begin
        int base;
        int lim;
        idle();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        reset = 1;

        // Two dispatch groups, oldPhyReg 10..17
        setDisp(4'b1111, 10); step();
        setDisp(4'b1111, 14); step();
        chk("plan_count8", 32'(alCount), 8);
        chk("plan_tail8", 32'(alTail), 8);

        // Complete 0,1,3: only 0 and 1 retire
        setWb(0, 0, 0); setWb(1, 1, 0); setWb(2, 3, 0); step();
        step();
        chk("plan_cv0", 32'(cv0), 1);
        chk("plan_cv1", 32'(cv1), 1);
        chk("plan_cr0", 32'(cr0), 10);
        chk("plan_cr1", 32'(cr1), 11);
        chk("plan_cnt2", 32'(commitCount), 2);
        chk("plan_head2", 32'(alHead), 2);

        setWb(0, 2, 0); setWb(1, 4, 0); setWb(2, 5, 0); setWb(3, 6, 0); step();
        setWb(0, 7, 0); step();
        step();
        step();
        chk("drain1_count", 32'(alCount), 0);

        // Mixed hasDest mask 1,0,1,1
        setDisp(4'b1101, 20); step();
        for (int k = 0; k < 4; k++) setWb(k, 8 + k, 0);
        step();
        step();
        chk("mask_cv0", 32'(cv0), 1);
        chk("mask_cv1", 32'(cv1), 0);
        chk("mask_cv2", 32'(cv2), 1);
        chk("mask_cv3", 32'(cv3), 1);
        chk("mask_cr1", 32'(cr1), 0);
        chk("mask_cr3", 32'(cr3), 23);
        chk("mask_cnt4", 32'(commitCount), 4);

        // Exception on head+1 with dispatch requested in the flush cycle
        setDisp(4'b1111, 30); step();
        setWb(0, 12, 0); setWb(1, 13, 1); setWb(2, 14, 0); setWb(3, 15, 0); step();
        setDisp(4'b1111, 40); step();
        chk("exc_cnt2", 32'(commitCount), 2);
        chk("exc_recover", 32'(recoverFlag), 1);
        chk("exc_count0", 32'(alCount), 0);
        chk("exc_head16", 32'(alHead), 16);
        chk("exc_tail16", 32'(alTail), 16);
        setDisp(4'b1111, 50); step();
        chk("exc_recover_off", 32'(recoverFlag), 0);
        chk("exc_blocked", 32'(alCount), 0);

        // Advance to head=tail=60, then wrap
        for (int i = 0; i < 16 && mTail != 60; i++) begin
            base = mTail;
            setDisp(4'($urandom), 60); step();
            for (int k = 0; k < 4; k++) setWb(k, base + k, 0);
            step();
            step();
        end
        chk("wrap_head60", 32'(alHead), 60);
        setDisp(4'b1111, 100); step();
        chk("wrap_tail0", 32'(alTail), 0);
        for (int k = 0; k < 4; k++) setWb(k, 60 + k, 0);
        step();
        step();
        chk("wrap_cnt4", 32'(commitCount), 4);
        chk("wrap_head0", 32'(alHead), 0);
        chk("wrap_count0", 32'(alCount), 0);

        // Random traffic including full stalls, stray indices and rare exceptions
        for (int c = 0; c < 400; c++) begin
            if ($urandom % 3 != 0) begin
                dispatchEn = 1;
                for (int k = 0; k < 4; k++) begin
                    hasDest[k] = 1'($urandom);
                    oldPhy[k]  = 7'($urandom);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom % 2 == 0) begin
                    lim = (q.size() < 8) ? q.size() : 8;
                    if (lim > 0 && $urandom % 8 != 0)
                        setWb(k, q[$urandom % lim].idx, ($urandom % 40) == 0);
                    else
                        setWb(k, $urandom % SZ, 0);
                end
            end
            step();
        end

        // Drain without exceptions
        for (int c = 0; c < 200 && (q.size() > 0 || mRecover); c++) begin
            lim = (q.size() < 4) ? q.size() : 4;
            for (int k = 0; k < lim; k++) setWb(k, q[k].idx, 0);
            step();
        end
        chk("drain_empty", 32'(alCount), 0);

        // Fill to full; extra dispatches are dropped
        for (int i = 0; i < 18; i++) begin
            setDisp(4'b1111, i); step();
        end
        chk("full_flag", 32'(alFull), 1);
        chk("full_count", 32'(alCount), 64);

        // Asynchronous reset mid-cycle
        #2;
        reset = 0;
        #1;
        modelReset();
        checkAll();
        chk("rst_full", 32'(alFull), 0);
        @(negedge clk);
        reset = 1;
        setDisp(4'b1111, 5); step();
        chk("post_rst_count", 32'(alCount), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/active_list_retire.md
Name: active_list_retire

Overview:
- In-order active list (ROB) between dispatch and the speculative free list.
- Records each dispatched instruction's previous physical mapping and collects completion and exception status from writeback.
- Retires up to 4 consecutive completed instructions per cycle in program order.
- Drives the free list's commitValid/commitReg inputs and raises a one-cycle recovery flush on an excepting instruction.

Parameters:
SIZE_ACTIVE_LIST, 64, entry count; power of two, multiple of 4, >= 8
SIZE_ACTIVE_LIST_LOG, 6, log2(SIZE_ACTIVE_LIST)
SIZE_PHYSICAL_LOG, 7, physical register tag width
DISPATCH_WIDTH, 4, entries allocated per dispatch and maximum retired per cycle; fixed at 4

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset; clears all state immediately
dispatchEn_i  in  1  allocate 4 entries this cycle; ignored if alFull_o or recoverFlag_o
hasDest0_i..hasDest3_i  in  1 each  slot k writes a destination register
oldPhyReg0_i..oldPhyReg3_i  in  SIZE_PHYSICAL_LOG each  previous mapping of slot k's destination
doneValid0_i..doneValid3_i  in  1 each  writeback port k completes an entry
doneIdx0_i..doneIdx3_i  in  SIZE_ACTIVE_LIST_LOG each  entry index for port k
doneExcept0_i..doneExcept3_i  in  1 each  entry raised an exception
alTail_o  out  SIZE_ACTIVE_LIST_LOG  index given to dispatch slot 0; slots 1-3 use +1..+3 mod SIZE
alHead_o  out  SIZE_ACTIVE_LIST_LOG  oldest entry index
alCount_o  out  SIZE_ACTIVE_LIST_LOG+1  occupied entries
alFull_o  out  1  alCount_o > SIZE_ACTIVE_LIST-4
commitValid0_o..commitValid3_o  out  1 each  retire slot k frees commitRegk_o
commitReg0_o..commitReg3_o  out  SIZE_PHYSICAL_LOG each  old physical register being freed
commitCount_o  out  3  instructions retired (0-4)
recoverFlag_o  out  1  one-cycle flush pulse

Behaviour:
- Reset (asserted low, async):
  - head=tail=count=0; all done/except bits 0.
  - All commit outputs, commitCount_o and recoverFlag_o are 0; alFull_o=0.
- Dispatch: when dispatchEn_i && !alFull_o && !recoverFlag_o && !flushNow:
  - Write entries tail..tail+3 with hasDest/oldPhyReg; clear their done/except.
  - tail += 4 mod SIZE.
  - Otherwise dispatch is dropped; no partial allocation.
- Writeback:
  - doneValidk_i sets done[doneIdxk_i] and ORs doneExceptk_i into except[].
  - Duplicate indices across ports OR together.
  - Status becomes visible to retire logic the next cycle.
  - Writeback to an unoccupied index is ignored.
- Retire selection (combinational from registered state):
  - Candidate k (0..3) at head+k mod SIZE retires iff k < count, done[head+k] is set, every candidate j<k retires, and no candidate j<k has except set.
  - An excepting entry retires as the last of its group.
  - A not-done entry blocks all younger candidates.
- Retire update:
  - head += n mod SIZE; done/except bits of retired entries cleared.
  - count_next = count + 4*dispatched - n.
  - Simultaneous dispatch and retire are both applied.
  - Head/tail wrap at SIZE_ACTIVE_LIST.
- Commit outputs are registered, 1-cycle latency after the retire decision:
  - commitValidk_o = retired_k && hasDest_k; commitRegk_o = oldPhyReg_k, else 0.
  - commitCount_o = n.
  - Slots need not be contiguous; the free list accepts any mask.
- Exception (flushNow: a retiring candidate has except set):
  - Same edge: head <= tail, count <= 0, all done/except cleared, dispatch suppressed.
  - recoverFlag_o = 1 next cycle, alongside that group's commit outputs; 0 the following cycle.
  - Dispatch is blocked while recoverFlag_o is high.
- Full: count == SIZE with no retire holds alFull_o=1; no overwrite.
- Empty: count=0 gives n=0 and all commitValid 0.

Decomposition:
- Shared package: SIZE_ACTIVE_LIST, SIZE_ACTIVE_LIST_LOG, SIZE_PHYSICAL_LOG, DISPATCH_WIDTH, and the entry payload typedef {hasDest, oldPhyReg}.
- One sub-module, al_payload_ram:
  - 4R4W payload storage, SIZE_ACTIVE_LIST x (SIZE_PHYSICAL_LOG+1).
  - Read ports addressed head+0..3, write ports tail+0..3.
  - Asynchronous read; synchronous write; no reset needed.
- done/except bits stay in flops in the top module for multi-port set/clear and flush.

Test Plan:
- Reset release, dispatch x2 with hasDest=1, oldPhyReg 10-17 -> alCount_o=8, alTail_o=8, all commitValid 0.
- Complete entries 0,1,3 -> next cycle retire 2; the following cycle commitValid0/1=1, commitReg0/1=10/11, commitCount_o=2, alHead_o=2.
- Wrap: head=tail=60, dispatch 4, complete 60-63 -> alTail_o=0; commit freed 4; alHead_o=0; count 0.
- Mixed mask: 4 done entries with hasDest 1,0,1,1 -> commitValid pattern 1011, commitCount_o=4.
- Exception on entry head+1 with head+0..3 done, dispatchEn_i=1 that cycle -> commitCount_o=2, recoverFlag_o=1 for exactly one cycle; alCount_o=0; dispatch not performed; alHead_o equals pre-flush tail.
- Full/async reset: dispatch to count 64 -> alFull_o=1, further dispatch ignored; assert reset low mid-cycle -> all outputs 0 immediately.
